bus_arbiter4: RTL and testbench

Four-port arbiter that shares one WIDTH-bit result bus between four requesters, using a 4:1 datapath multiplexer driven by a registered select. It sits in front of a single consumer (register-file write port or memory-stage bus), grants one requester at a time with round-robin fairness, and completes each transfer with a valid/ready handshake to the consumer and a one-cycle ack back to the winner.

---
 rtl/bus_arbiter4_pkg.sv | 21 ++
 rtl/bus_arbiter4_if.sv | 30 +++
 rtl/bus_arbiter4_mux4.sv | 23 ++
 rtl/bus_arbiter4.sv | 95 +++++++++
 tb/tb_bus_arbiter4.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter4_pkg.sv
// Shared constants and types for the four-port round-robin bus arbiter.
// Arbitration mode is selected in bus_arbiter4 by ARB_FIXED_PRIORITY_EN.
package bus_arbiter4_pkg;

  localparam int NREQ      = 4;
  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot requester mask for a 2-bit requester index.
  function automatic logic [NREQ-1:0] sel_onehot(input logic [1:0] sel);
    logic [NREQ-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Requester/consumer bundle of the arbiter.
// The arbiter uses the slave modport; whoever drives requests and consumes words uses master.
interface bus_arbiter4_if
  import bus_arbiter4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic [NREQ-1:0]  ack;

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  out_valid, out_data, out_sel, ack
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output out_valid, out_data, out_sel, ack
  );

endinterface

// File: rtl/bus_arbiter4_mux4.sv
// Plain 4:1 datapath multiplexer, WIDTH bits wide.
module bus_arbiter4_mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester bus arbiter: round-robin grant, registered mux output, valid/ready to the consumer.
// Define ARB_FIXED_PRIORITY_EN to freeze the pointer at 0 (lowest index always wins).
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter4_if.slave bus
);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       mux_sel;
  logic [1:0]       out_sel_q;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             xfer;

  // Rotate req so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  function automatic logic [1:0] pick_winner(input logic [NREQ-1:0] r, input logic [1:0] p);
    logic [NREQ-1:0] rot;
    logic [1:0]      idx;
    logic [1:0]      k;
    for (int i = 0; i < NREQ; i++) begin
      k      = 2'(i) + p;
      rot[i] = r[k];
    end
    idx = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = 2'(i);
    end
    return idx + p;
  endfunction

  assign win     = pick_winner(bus.req, ptr);
  assign mux_sel = (state == IDLE) ? win : out_sel_q;
  assign xfer    = out_valid_q & bus.out_ready;

  bus_arbiter4_mux4 #(.WIDTH(WIDTH)) u_mux (
    .sel (mux_sel),
    .in0 (bus.d0),
    .in1 (bus.d1),
    .in2 (bus.d2),
    .in3 (bus.d3),
    .out (mux_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            out_sel_q   <= win;
            out_data_q  <= mux_out;
            out_valid_q <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // The IDLE bubble after every accept forces re-arbitration before a repeat grant.
          if (xfer) begin
            out_valid_q <= 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
            ptr         <= 2'd0;
`else
            ptr         <= out_sel_q + 2'd1;
`endif
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  // A word caught by reset is dropped silently, so reset also masks the ack.
  always_comb begin
    bus.ack = '0;
    if (xfer && !reset) bus.ack = sel_onehot(out_sel_q);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: scoreboard of expected grants checked at every accept.
// Expectations follow ARB_FIXED_PRIORITY_EN when the bench is built with it.
module tb_bus_arbiter4;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  exp_t sb[$];
  exp_t mon_e;

  bus_arbiter4_if #(.WIDTH(32)) bus ();

  bus_arbiter4 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #1;
    bus.req       = r;
    bus.out_ready = rdy;
  endtask

  task automatic pushExp(input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    e.sel  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // Every accepted word must match the head of the scoreboard; ack must be silent otherwise.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && reset === 1'b0) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_accept", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("acc_data", 64'(bus.out_data), 64'(mon_e.data));
        checkOutput("acc_sel", 64'(bus.out_sel), 64'(mon_e.sel));
        checkOutput("acc_ack", 64'(bus.ack), 64'(4'b0001 << mon_e.sel));
      end
    end else begin
      checkOutput("ack_quiet", 64'(bus.ack), 64'd0);
    end
  end

  initial begin
    checks        = 0;
    passes        = 0;
    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.d0        = 32'h0;
    bus.d1        = 32'h0;
    bus.d2        = 32'h0;
    bus.d3        = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset and idle");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("idle_data", 64'(bus.out_data), 64'd0);
      checkOutput("idle_sel", 64'(bus.out_sel), 64'd0);
      checkOutput("idle_ack", 64'(bus.ack), 64'd0);
    end

    $display("[TB] single request");
    bus.d2 = 32'hC;
    pushExp(2'd2, 32'hC);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("single_c0_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("single_c1_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("single_c1_ack", 64'(bus.ack), 64'h4);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("single_c2_valid", 64'(bus.out_valid), 64'd0);

    // Reset brings the pointer back to 0 before the rotation test.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] round robin");
    bus.d0 = 32'hA;
    bus.d1 = 32'hB;
    bus.d2 = 32'hC;
    bus.d3 = 32'hD;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 5; i++) pushExp(2'd0, 32'hA);
`else
    pushExp(2'd0, 32'hA);
    pushExp(2'd1, 32'hB);
    pushExp(2'd2, 32'hC);
    pushExp(2'd3, 32'hD);
    pushExp(2'd0, 32'hA);
`endif
    applyStimulus(4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("rr_c0_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 1; i < 10; i++) begin
      applyStimulus(4'b1111, 1'b1);
      @(negedge clk);
      checkOutput("rr_valid_alt", 64'(bus.out_valid), 64'(i % 2));
    end
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("rr_end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rr_sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] consumer stall");
    pushExp(2'd1, 32'hB);
    applyStimulus(4'b0010, 1'b0);
    @(negedge clk);
    checkOutput("stall_c0_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(4'b0010, 1'b0);
      @(negedge clk);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_data", 64'(bus.out_data), 64'hB);
      checkOutput("stall_sel", 64'(bus.out_sel), 64'd1);
    end
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("stall_release_ack", 64'(bus.ack), 64'h2);
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("stall_after_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] pointer wrap");
    pushExp(2'd3, 32'hD);
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("wrap_c0_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("wrap_c1_sel", 64'(bus.out_sel), 64'd3);
    pushExp(2'd0, 32'hA);
    applyStimulus(4'b1001, 1'b1);
    @(negedge clk);
    checkOutput("wrap_bubble_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'b1001, 1'b1);
    @(negedge clk);
    checkOutput("wrap_next_sel", 64'(bus.out_sel), 64'd0);
    checkOutput("wrap_next_data", 64'(bus.out_data), 64'hA);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("wrap_end_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] reset during grant");
    applyStimulus(4'b0100, 1'b0);
    @(negedge clk);
    checkOutput("rstg_c0_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'b0100, 1'b0);
    @(negedge clk);
    checkOutput("rstg_c1_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstg_no_ack", 64'(bus.ack), 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    checkOutput("rstg_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstg_data", 64'(bus.out_data), 64'd0);
    checkOutput("rstg_sel", 64'(bus.out_sel), 64'd0);

    repeat (2) @(negedge clk);
    checkOutput("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
